// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift sequencer: FSM states, shift directions, step counter width.
package shift_seq_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ODD  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/Shifter_2_32.sv
// Combinational 2-bit logical shifter; zero fill, selects are one-hot.
module Shifter_2_32 (
    input  logic [31:0] IN,
    input  logic        L_SHIFT,
    input  logic        NO_SHIFT,
    input  logic        R_SHIFT,
    output logic [31:0] OUT
);

    always_comb begin
        OUT = IN;
        case ({L_SHIFT, NO_SHIFT, R_SHIFT})
            3'b100:  OUT = {IN[29:0], 2'b00};
            3'b001:  OUT = {2'b00, IN[31:2]};
            default: OUT = IN;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle logical shifter: optional 1-bit pre-step, then one 2-bit step per cycle.
// Result lands in DOUT on entry to DONE; START is only honoured in IDLE.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             DIR,
    input  logic [AMT_W-1:0] AMT,
    input  logic [WIDTH-1:0] DIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DOUT
);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [WIDTH-1:0]   shf_out;
    logic               L_SHIFT, NO_SHIFT, R_SHIFT;

    // Selects stay one-hot: only STEP moves the 2-bit shifter off NO_SHIFT.
    always_comb begin
        L_SHIFT  = 1'b0;
        R_SHIFT  = 1'b0;
        NO_SHIFT = 1'b1;
        if (state_q == S_STEP) begin
            L_SHIFT  = (dir_q == DIR_LEFT);
            R_SHIFT  = (dir_q == DIR_RIGHT);
            NO_SHIFT = 1'b0;
        end
    end

    Shifter_2_32 u_shifter (
        .IN       (work_q),
        .L_SHIFT  (L_SHIFT),
        .NO_SHIFT (NO_SHIFT),
        .R_SHIFT  (R_SHIFT),
        .OUT      (shf_out)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    work_d = DIN;
                    dir_d  = DIR;
                    cnt_d  = AMT[AMT_W-1:1];
                    if (AMT[0])
                        state_d = S_ODD;
                    else if (AMT[AMT_W-1:1] != '0)
                        state_d = S_STEP;
                    else
                        state_d = S_DONE;
                end
            end
            S_ODD: begin
                work_d  = (dir_q == DIR_RIGHT) ? {1'b0, work_q[WIDTH-1:1]}
                                               : {work_q[WIDTH-2:0], 1'b0};
                state_d = (cnt_q != '0) ? S_STEP : S_DONE;
            end
            S_STEP: begin
                work_d  = shf_out;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_STEP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // DOUT captures the final working value on the edge that enters DONE.
        if (state_d == S_DONE && state_q != S_DONE)
            dout_d = work_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_LEFT;
            cnt_q   <= '0;
            work_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
        end
    end

    assign BUSY = (state_q == S_ODD) || (state_q == S_STEP);
    assign DONE = (state_q == S_DONE);
    assign DOUT = dout_q;

endmodule
